// File: rtl/hmi_uart_rx.sv
// 8N1 serial byte receiver feeding the HMI command unit; dout_rdy is a fixed-length level pulse.
// Defining HMI_RX_PARITY_EN switches the frame format to 8E1 (adds a PARITY state).
module hmi_uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned RDY_HOLD     = 8
) (
    input  logic       clk,
    input  logic       res,
    input  logic       rxd,
    output logic [7:0] dout,
    output logic       dout_rdy,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int unsigned RDY_W     = $clog2(8 * CLKS_PER_BIT + 1);
    localparam logic [15:0] HALF_LOAD = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] BIT_LOAD  = 16'(CLKS_PER_BIT - 1);
    localparam logic [RDY_W-1:0] RDY_LOAD = RDY_W'(RDY_HOLD);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef HMI_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t           state_q, state_d;
    logic             rxd_s1_q, rxd_s2_q, rxd_s3_q;
    logic [15:0]      timer_q, timer_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       dout_q, dout_d;
    logic [RDY_W-1:0] rdy_cnt_q, rdy_cnt_d;
    logic             frame_err_q, frame_err_d;
`ifdef HMI_RX_PARITY_EN
    logic             par_err_q, par_err_d;
`endif

    logic rxd_sync, rxd_fall, tick;

    assign rxd_sync = rxd_s2_q;
    assign rxd_fall = rxd_s3_q & ~rxd_s2_q;
    assign tick     = (timer_q == '0);

    // Timer stops at zero, so a sample point is the single cycle with tick set
    // inside a sampling state; every sample reloads the full bit period.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        dout_d      = dout_q;
        frame_err_d = 1'b0;
        rdy_cnt_d   = (rdy_cnt_q != '0) ? rdy_cnt_q - RDY_W'(1) : rdy_cnt_q;
`ifdef HMI_RX_PARITY_EN
        par_err_d   = par_err_q;
`endif
        if (state_q != S_IDLE && !tick) begin
            timer_d = timer_q - 16'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (rxd_fall) begin
                    state_d = S_START;
                    timer_d = HALF_LOAD;
                end
            end
            S_START: begin
                if (tick) begin
                    if (!rxd_sync) begin
                        state_d   = S_DATA;
                        bit_idx_d = '0;
                        timer_d   = BIT_LOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_d   = {rxd_sync, shift_q[7:1]};
                    timer_d   = BIT_LOAD;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef HMI_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef HMI_RX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    par_err_d = (^shift_q) ^ rxd_sync;
                    timer_d   = BIT_LOAD;
                    state_d   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
`ifdef HMI_RX_PARITY_EN
                    if (par_err_q) begin
                        frame_err_d = 1'b1;
                        state_d     = rxd_sync ? S_IDLE : S_WAIT_IDLE;
                    end else
`endif
                    if (rxd_sync) begin
                        dout_d    = shift_q;
                        rdy_cnt_d = RDY_LOAD;
                        state_d   = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (rxd_sync) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            rxd_s1_q    <= 1'b1;
            rxd_s2_q    <= 1'b1;
            rxd_s3_q    <= 1'b1;
            state_q     <= S_IDLE;
            timer_q     <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            dout_q      <= '0;
            rdy_cnt_q   <= '0;
            frame_err_q <= 1'b0;
`ifdef HMI_RX_PARITY_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            rxd_s1_q    <= rxd;
            rxd_s2_q    <= rxd_s1_q;
            rxd_s3_q    <= rxd_s2_q;
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            dout_q      <= dout_d;
            rdy_cnt_q   <= rdy_cnt_d;
            frame_err_q <= frame_err_d;
`ifdef HMI_RX_PARITY_EN
            par_err_q   <= par_err_d;
`endif
        end
    end

    assign dout      = dout_q;
    assign dout_rdy  = (rdy_cnt_q != '0);
    assign frame_err = frame_err_q;
    assign rx_busy   = (state_q != S_IDLE);

endmodule

// File: doc/hmi_uart_rx.md
Name: hmi_uart_rx

Overview:
- Serial byte receiver directly upstream of the HMI command unit; the command unit consumes this block's dout/dout_rdy as its din/din_rdy.
- Receives 8N1 asynchronous serial frames on rxd, LSB first.
- Holds each received byte stable on dout and raises dout_rdy as a level pulse of fixed length, so the command unit's edge synchroniser detects exactly one byte per frame.
- Rejects framing errors and false start bits.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200). Legal range 8..65535.
- RDY_HOLD, 8, clk cycles dout_rdy stays high per accepted byte. Legal range 4..(8*CLKS_PER_BIT).

Ports:
- clk  input  1  system clock
- res  input  1  asynchronous reset, active high
- rxd  input  1  serial line, idle high, asynchronous to clk
- dout  output  8  last accepted byte
- dout_rdy  output  1  high for RDY_HOLD cycles per accepted byte
- frame_err  output  1  one-cycle pulse on bad stop bit (or bad parity, see Optional Feature)
- rx_busy  output  1  high from start-bit detection until return to IDLE

Behaviour:
- Clock and reset: single clock clk; reset res is asynchronous, active high.
- Reset values: dout=0x00, dout_rdy=0, frame_err=0, rx_busy=0, synchroniser flops=1, state=IDLE, all counters=0.
- rxd input: passes through a 2-flop synchroniser, then one further registered copy for falling-edge detection. All sampling uses the synchronised signal.
- Bit timer: 16-bit down counter reloaded per bit. Mid-bit sample point is CLKS_PER_BIT/2 (integer divide) after start-edge detection, then every CLKS_PER_BIT thereafter.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE (plus PARITY when the optional feature is enabled).
  - IDLE: a falling edge on synced rxd moves to START, sets rx_busy=1 and loads the half-bit count.
  - START: at the half-bit point, rxd=0 moves to DATA with bit index 0. rxd=1 is a false start: return to IDLE with no output and no error.
  - DATA: sample at each mid-bit into a shift register, LSB first. After bit index 7 go to STOP.
  - STOP: sample at mid-bit.
    - rxd=1: dout <= shift register, dout_rdy=1 from the next cycle, return to IDLE.
    - rxd=0: frame_err pulses for 1 cycle, dout unchanged, no dout_rdy, go to WAIT_IDLE.
  - WAIT_IDLE: stay until synced rxd=1 (break or garbage), then go to IDLE. No new start is detected in this state.
- rx_busy is low in IDLE, high in every other state.
- dout_rdy: driven by an RDY_HOLD down counter, independent of the FSM.
  - A new byte is accepted only after the previous hold has expired; this is guaranteed by the RDY_HOLD range limit.
  - dout is stable for the whole hold and until the next accepted byte.
- Receive latency: dout_rdy rises 1 clk after the stop-bit mid sample, i.e. about 9.5 bit times after the start edge (plus 3 synchroniser cycles).
- Back-to-back frames: a start edge immediately following the stop-bit sample (same bit period) must be detected. IDLE is re-entered before the stop bit ends.
- Reset mid-frame: all state clears immediately; the partial byte is discarded; no dout_rdy.

Optional Feature:
- Macro: HMI_RX_PARITY_EN.
- Defined: frames are 8E1. A PARITY state follows DATA and samples the 9th bit.
  - If data XOR parity bit is 1 (parity mismatch): frame_err pulses at the stop-bit sample, the byte is discarded, and the FSM goes to IDLE, or to WAIT_IDLE if the stop bit is also 0.
  - Otherwise the frame is handled exactly as in the base behaviour.
- Undefined: 8N1 only; no PARITY state and no parity logic is synthesised.

Test Plan:
- Reset, then send 0x85 at CLKS_PER_BIT=434 -> dout=0x85; dout_rdy high exactly 8 cycles; frame_err stays 0; rx_busy falls at the stop sample.
- rxd low glitch of 100 cycles (< half bit) -> returns to IDLE; dout stays 0x00; no dout_rdy; no frame_err.
- Send 0x41 with stop bit forced 0, line held low for 3 bit times, then 0xC3 -> frame_err single pulse; dout stays at previous value; 0xC3 is accepted after the line returns high.
- Send 0x41 then 0xC3 back-to-back with no idle gap -> two separate 8-cycle dout_rdy pulses; dout=0x41 then 0xC3.
- Assert res during data bit 4 of 0xFF, release, send 0x06 -> no output for 0xFF; dout=0x06 with one dout_rdy pulse.
- HMI_RX_PARITY_EN defined: 0x03 with parity bit 0 -> accepted; 0x03 with parity bit 1 -> frame_err pulse, no dout_rdy.
